// File: rtl/audio_pkg.sv
// Shared types and default note constants for the melody player.
// Provides the player FSM state enum, half-period constants for common
// pitches at a 100 MHz clock, and a default 8-entry note table packed as
// {half[19:0], beats[3:0]} per entry, entry 0 in the least significant bits.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TONE,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_HALF_W = 20;
  localparam int unsigned DEF_BEAT_W = 4;
  localparam int unsigned DEF_ENTRY_W = DEF_HALF_W + DEF_BEAT_W;

  // Half periods in clk cycles at 100 MHz: 100e6 / (2 * f)
  localparam logic [DEF_HALF_W-1:0] HALF_REST = 20'd0;
  localparam logic [DEF_HALF_W-1:0] HALF_A4   = 20'd113_636;
  localparam logic [DEF_HALF_W-1:0] HALF_C5   = 20'd95_556;
  localparam logic [DEF_HALF_W-1:0] HALF_E5   = 20'd75_843;
  localparam logic [DEF_HALF_W-1:0] HALF_G5   = 20'd63_776;

  localparam logic [8*DEF_ENTRY_W-1:0] DEFAULT_TABLE = {
    HALF_REST, 4'd0,   // 7: end marker
    HALF_A4,   4'd2,   // 6
    HALF_G5,   4'd1,   // 5
    HALF_REST, 4'd1,   // 4: rest
    HALF_G5,   4'd2,   // 3
    HALF_E5,   4'd1,   // 2
    HALF_C5,   4'd1,   // 1
    HALF_A4,   4'd2    // 0
  };

endpackage

// File: rtl/melody_rom.sv
// Combinational note table lookup.
// Ports:
//   idx       - index of the current entry
//   nxt_idx   - index of the following entry
//   half      - half period of entry idx (0 = rest)
//   beats     - beat count of entry idx (0 = end marker)
//   nxt_beats - beat count of entry nxt_idx
// Indices beyond the table read as all-zero, i.e. an end marker.
module melody_rom #(
  parameter int unsigned NOTE_COUNT = 8,
  parameter int unsigned HALF_W     = 20,
  parameter int unsigned BEAT_W     = 4,
  parameter int unsigned IDX_W      = 3,
  parameter logic [NOTE_COUNT*(HALF_W+BEAT_W)-1:0] NOTE_TABLE = '0
) (
  input  logic [IDX_W-1:0]  idx,
  input  logic [IDX_W-1:0]  nxt_idx,
  output logic [HALF_W-1:0] half,
  output logic [BEAT_W-1:0] beats,
  output logic [BEAT_W-1:0] nxt_beats
);

  localparam int unsigned ENTRY_W = HALF_W + BEAT_W;

  always_comb begin
    half      = '0;
    beats     = '0;
    nxt_beats = '0;
    for (int unsigned i = 0; i < NOTE_COUNT; i++) begin
      if (idx == IDX_W'(i)) begin
        {half, beats} = NOTE_TABLE[i*ENTRY_W +: ENTRY_W];
      end
      if (nxt_idx == IDX_W'(i)) begin
        nxt_beats = NOTE_TABLE[i*ENTRY_W +: BEAT_W];
      end
    end
  end

endmodule

// File: rtl/melody_player.sv
// Tone sequencer: plays a note table as a square wave on speaker.
// Ports:
//   clk         - system clock
//   rst         - synchronous active-high reset
//   enable      - level-sensitive play request; low returns to IDLE
//   repeat_mode - 1 loops the melody, 0 plays once
//   speaker     - registered square-wave output
//   playing     - high while in TONE or GAP
//   note_idx    - index of the current table entry
//   done        - one-cycle pulse when a play-once melody finishes
module melody_player
  import audio_pkg::*;
#(
  parameter int unsigned NOTE_COUNT  = 8,
  parameter int unsigned HALF_W      = 20,
  parameter int unsigned BEAT_W      = 4,
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 1_000_000,
  parameter logic [NOTE_COUNT*(HALF_W+BEAT_W)-1:0] NOTE_TABLE = DEFAULT_TABLE,
  localparam int unsigned IDX_W = (NOTE_COUNT > 1) ? $clog2(NOTE_COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             repeat_mode,
  output logic             speaker,
  output logic             playing,
  output logic [IDX_W-1:0] note_idx,
  output logic             done
);

  localparam longint unsigned DUR_MAX = ((longint'(1) << BEAT_W) - 1) * BEAT_CYCLES;
  localparam int unsigned DUR_W = $clog2(DUR_MAX + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n, nxt_idx;
  logic [HALF_W-1:0] div, div_n;
  logic [DUR_W-1:0]  dur, dur_n, dur_last;
  logic [GAP_W-1:0]  gap, gap_n;
  logic              spk, spk_n;
  logic              done_q, done_n;
  logic              advance;
  logic              is_last;

  logic [HALF_W-1:0] cur_half;
  logic [BEAT_W-1:0] cur_beats, nxt_beats;

  assign nxt_idx = idx + IDX_W'(1);
  assign is_last = (idx == IDX_W'(NOTE_COUNT - 1));

  melody_rom #(
    .NOTE_COUNT (NOTE_COUNT),
    .HALF_W     (HALF_W),
    .BEAT_W     (BEAT_W),
    .IDX_W      (IDX_W),
    .NOTE_TABLE (NOTE_TABLE)
  ) u_rom (
    .idx       (idx),
    .nxt_idx   (nxt_idx),
    .half      (cur_half),
    .beats     (cur_beats),
    .nxt_beats (nxt_beats)
  );

  // Last TONE cycle of the current note; never evaluated with beats = 0.
  assign dur_last = DUR_W'(cur_beats) * DUR_W'(BEAT_CYCLES) - DUR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      div    <= '0;
      dur    <= '0;
      gap    <= '0;
      spk    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      div    <= div_n;
      dur    <= dur_n;
      gap    <= gap_n;
      spk    <= spk_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    div_n   = div;
    dur_n   = dur;
    gap_n   = gap;
    spk_n   = spk;
    done_n  = 1'b0;
    advance = 1'b0;

    if (!enable) begin
      state_n = ST_IDLE;
      idx_n   = '0;
      div_n   = '0;
      dur_n   = '0;
      gap_n   = '0;
      spk_n   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx_n = '0;
          div_n = '0;
          dur_n = '0;
          gap_n = '0;
          spk_n = 1'b0;
          // idx is 0 here, so cur_beats is entry 0
          if (cur_beats == '0) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_TONE;
          end
        end
        ST_TONE: begin
          if (dur == dur_last) begin
            spk_n = 1'b0;
            div_n = '0;
            dur_n = '0;
            gap_n = '0;
            if (GAP_CYCLES == 0) advance = 1'b1;
            else state_n = ST_GAP;
          end else begin
            dur_n = dur + 1'b1;
            if (cur_half != '0) begin
              if (div == cur_half - 1'b1) begin
                div_n = '0;
                spk_n = ~spk;
              end else begin
                div_n = div + 1'b1;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap == GAP_W'(GAP_CYCLES - 1)) advance = 1'b1;
          else gap_n = gap + 1'b1;
        end
        ST_DONE: ;
        default: state_n = ST_IDLE;
      endcase
    end

    // Shared next-note step, reached from the end of GAP or directly from TONE
    // when there is no gap, so the next TONE starts with no dead cycle.
    if (advance) begin
      div_n = '0;
      dur_n = '0;
      gap_n = '0;
      spk_n = 1'b0;
      if (!is_last && nxt_beats != '0) begin
        idx_n   = nxt_idx;
        state_n = ST_TONE;
      end else if (repeat_mode) begin
        idx_n   = '0;
        state_n = ST_TONE;
      end else begin
        state_n = ST_DONE;
        done_n  = 1'b1;
      end
    end
  end

  assign speaker  = spk;
  assign playing  = (state == ST_TONE) || (state == ST_GAP);
  assign note_idx = idx;
  assign done     = done_q;

endmodule

// File: doc/melody_player.md
# melody_player

Parametrised tone sequencer that drives a 1-bit square-wave `speaker` output from a small note table instead of one fixed pitch. Each table entry gives a pitch and a duration. The block plays the entries in order, with an optional silent gap between notes, and either stops or loops at the end of the table. It sits between the reminder/alarm control logic (which raises `enable`) and the audio pin's low-pass filter.

## Interface
- `NOTE_COUNT`, default 8: number of table entries; must be ≥ 1.
- `HALF_W`, default 20: width of the half-period field, in clk cycles.
- `BEAT_W`, default 4: width of the beats field.
- `BEAT_CYCLES`, default 25_000_000: clk cycles per beat (0.25 s at 100 MHz).
- `GAP_CYCLES`, default 1_000_000: silent cycles after each note; 0 means no gap.
- `clk` input 1: system clock, 100 MHz.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: level-sensitive play request.
- `repeat_mode` input 1: 1 = loop the melody, 0 = play once.
- `speaker` output 1: square-wave audio, registered.
- `playing` output 1: high in TONE or GAP.
- `note_idx` output $clog2(NOTE_COUNT) (min 1): index of the current entry.
- `done` output 1: one-cycle pulse when a play-once melody finishes.

## Operation
- Table entry = {`half` [HALF_W], `beats` [BEAT_W]}.
  - `half` = 0 is a rest: `speaker` is held 0 for the note's duration.
  - `beats` = 0 is an end marker: the melody ends at this entry, which is not played.
- States: IDLE, TONE, GAP, DONE.
- IDLE: `speaker`=0, `note_idx`=0. `enable`=1 → TONE with index 0.
  - If entry 0 has `beats`=0, go directly to DONE and pulse `done`.
- TONE:
  - Divider counts 0..`half`-1. At `half`-1, `speaker` toggles and the divider clears.
  - Duration counter counts `beats`×BEAT_CYCLES cycles, then → GAP (or the next-note step if GAP_CYCLES=0).
  - `speaker` is forced to 0 when leaving TONE.
- GAP: `speaker`=0 for GAP_CYCLES cycles, then the next-note step.
- Next-note step:
  - Not the last entry, and the next entry has `beats`≠0: increment the index and enter TONE.
  - Otherwise, if `repeat_mode`=1: index 0 and TONE.
  - Otherwise: DONE with a one-cycle `done` pulse.
- DONE: `speaker`=0, `playing`=0. Stays in DONE until `enable`=0, then → IDLE.
- `enable`=0 in any state → IDLE on the next edge: `speaker` 0, counters cleared, no `done` pulse.
- `repeat_mode` is sampled only at the next-note step after the last entry.
- Width rules:
  - Duration counter width = $clog2((2^BEAT_W−1)×BEAT_CYCLES+1).
  - Gap counter width = $clog2(GAP_CYCLES+1).
  - All counters are unsigned and never wrap inside a note.

## Timing
- Reset values: `speaker`=0, `playing`=0, `note_idx`=0, `done`=0, state IDLE, all counters 0.
- `enable` is sampled at a clk edge. TONE is entered on that same edge, and `playing` is high the following cycle.
- First `speaker` rise: `half` cycles after TONE entry.
  - Tone period = 2×`half` cycles.
  - Frequency = CLK_HZ / (2×`half`).
- A note occupies exactly `beats`×BEAT_CYCLES cycles in TONE plus GAP_CYCLES in GAP. There are no extra dead cycles between GAP and the next TONE.
- `done` asserts in the first DONE cycle, for exactly one cycle.
- `rst` overrides `enable` in the same cycle.

## Structure
- Package `audio_pkg`: state enum and default note constants (A4 half = 113_636 at 100 MHz, etc.).
- Sub-module `melody_rom`: combinational lookup from index to {`half`, `beats`}. Contents come from a parameter array, so the player core stays table-agnostic.
- Core: one FSM, one divider counter, one duration counter, and one gap counter. The duration and gap counters may share a register.

## Test plan
Bench parameters: BEAT_CYCLES=20, GAP_CYCLES=4, NOTE_COUNT=3. Table = {half 5, beats 2}, {half 0, beats 1}, {half 3, beats 1}.
- Reset held, then released with `enable`=0 → all outputs 0 for 100 cycles.
- `enable`=1, `repeat_mode`=0 → waveform in order:
  - 40 cycles of period-10 square wave (first rise 5 cycles after entry).
  - 4 low, then 20 low (the rest), then 4 low.
  - 20 cycles of period-6 square wave, then 4 low.
  - Then a one-cycle `done` pulse, with `playing`=0 afterwards.
- Same run with `repeat_mode`=1 → `note_idx` returns to 0 immediately after the last gap. No `done` pulse; the pattern repeats identically.
- Drop `enable` mid-tone in entry 0 → next cycle `speaker`=0, `playing`=0, `note_idx`=0. Re-raising restarts from entry 0.
- Change entry 1 `beats` to 0 → the melody ends after entry 0's gap with `done`; entry 2 is never played.
- Assert `rst` mid-GAP with `enable`=1 → outputs return to reset values. Playback restarts at entry 0 on the first cycle after `rst` deasserts.
